// File: rtl/thermo_decoder_pipe_pkg.sv
// Shared TDC constants and helpers: code-width derivation for thermometer
// decoders, reused by the coarse/fine timestamp merger.
package tdc_pkg;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 32'sd0;
    span   = 32'sd1;
    for (int i = 0; i < 31; i++) begin
      if (span < value) begin
        span   = span * 32'sd2;
        result = result + 32'sd1;
      end
    end
    return result;
  endfunction

  // Width the search works on: the next all-ones size at or above w.
  function automatic int pad_width(input int w);
    return (32'sd1 <<< clog2(w + 32'sd1)) - 32'sd1;
  endfunction

  function automatic int out_width(input int w);
    return clog2(w + 32'sd1);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/thermo_decoder_pipe_if.sv
// Capture-side bus of the thermometer decoder: one valid strobe shared by
// all channels, packed per-channel data, codes and flags.
interface thermo_decoder_pipe_if
  import tdc_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 40
);
  localparam int OUT_W = out_width(WIDTH);

  logic                      in_valid;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic                      out_valid;
  logic [CHANNELS*OUT_W-1:0] code_out;
  logic [CHANNELS-1:0]       sat_out;
  logic [CHANNELS-1:0]       err_out;

  modport master (
    output in_valid, data_in,
    input  out_valid, code_out, sat_out, err_out
  );

  modport slave (
    input  in_valid, data_in,
    output out_valid, code_out, sat_out, err_out
  );
endinterface

// File: rtl/thermo_search_ch.sv
// One channel: capture register, optional majority bubble filter, then a
// halving search that resolves one code bit per pipeline stage.
module thermo_search_ch
  import tdc_pkg::*;
#(
  parameter int  WIDTH      = 40,
  parameter bit  BUBBLE_FIX = 1'b1,
  localparam int OUT_W      = out_width(WIDTH),
  localparam int P          = pad_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_i,
  output logic [OUT_W-1:0] code_o,
  output logic             sat_o,
  output logic             err_o
);

  logic [P-1:0]     word_q [OUT_W];
  logic [OUT_W-1:0] code_q [OUT_W];
  logic [OUT_W-1:0] code_d [1:OUT_W-1];
  logic [OUT_W-1:0] sat_q;
  logic [OUT_W-1:0] err_q;
  logic [WIDTH-1:0] filt_s;

  if (BUBBLE_FIX) begin : g_filt
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH+1:0] ext_s;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cap_q <= '0;
      else     cap_q <= word_i;
    end

    // Boundary taps: below bit 0 reads as filled, above the top as empty.
    assign ext_s = {1'b0, cap_q, 1'b1};

    always_comb begin
      filt_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
        filt_s[i] = maj3(ext_s[i], ext_s[i+1], ext_s[i+2]);
      end
    end
  end else begin : g_nofilt
    assign filt_s = word_i;
  end

  // Code bits above K mark the base of the surviving slice, so its middle
  // bit sits at base | (2^K - 1); a 1 there sets code bit K.
  always_comb begin
    for (int s = 1; s < OUT_W; s++) begin
      code_d[s] = code_q[s-1];
      if (word_q[s-1][code_q[s-1] | ((OUT_W'(1) << (OUT_W - s)) - OUT_W'(1))]) begin
        code_d[s] = code_q[s-1] | (OUT_W'(1) << (OUT_W - s));
      end else begin
        code_d[s] = code_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < OUT_W; s++) begin
        word_q[s] <= '0;
        code_q[s] <= '0;
      end
      sat_q <= '0;
      err_q <= '0;
    end else begin
      word_q[0] <= P'(filt_s);
      code_q[0] <= '0;
      sat_q     <= {sat_q[OUT_W-2:0], &filt_s};
      err_q     <= {err_q[OUT_W-2:0], |(filt_s[WIDTH-1:1] & ~filt_s[WIDTH-2:0])};
      for (int s = 1; s < OUT_W; s++) begin
        word_q[s] <= word_q[s-1];
        code_q[s] <= code_d[s];
      end
    end
  end

  assign code_o = code_q[OUT_W-1] | OUT_W'(word_q[OUT_W-1][code_q[OUT_W-1]]);
  assign sat_o  = sat_q[OUT_W-1];
  assign err_o  = err_q[OUT_W-1];

endmodule

// File: rtl/thermo_decoder_pipe.sv
// Multi-channel pipelined thermometer-to-binary decoder; the channels share
// one valid pipeline and a valid-gated output register bank.
module thermo_decoder_pipe
  import tdc_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 40,
  parameter bit BUBBLE_FIX = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  thermo_decoder_pipe_if.slave bus
);

  localparam int OUT_W = out_width(WIDTH);
  localparam int L     = OUT_W + 32'sd1 + int'(BUBBLE_FIX);

  logic [L-1:0]              vld_q;
  logic [CHANNELS*OUT_W-1:0] code_s;
  logic [CHANNELS*OUT_W-1:0] code_q;
  logic [CHANNELS-1:0]       sat_s;
  logic [CHANNELS-1:0]       sat_q;
  logic [CHANNELS-1:0]       err_s;
  logic [CHANNELS-1:0]       err_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    thermo_search_ch #(
      .WIDTH      (WIDTH),
      .BUBBLE_FIX (BUBBLE_FIX)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .word_i (bus.data_in[c*WIDTH +: WIDTH]),
      .code_o (code_s[c*OUT_W +: OUT_W]),
      .sat_o  (sat_s[c]),
      .err_o  (err_s[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[L-2:0], bus.in_valid};
  end

  // The last data stage only captures when a real word arrives, so idle
  // cycles leave the previous result on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= '0;
      sat_q  <= '0;
      err_q  <= '0;
    end else if (vld_q[L-2]) begin
      code_q <= code_s;
      sat_q  <= sat_s;
      err_q  <= err_s;
    end
  end

  assign bus.out_valid = vld_q[L-1];
  assign bus.code_out  = code_q;
  assign bus.sat_out   = sat_q;
  assign bus.err_out   = err_q;

endmodule

// File: tb/tb_thermo_decoder_pipe.sv
// Directed bench for thermo_decoder_pipe: one instance with the bubble
// filter and one without, driven with identical stimulus.
module tb_thermo_decoder_pipe;
  localparam int CH = 2;
  localparam int W  = 40;
  localparam int OW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  thermo_decoder_pipe_if #(.CHANNELS(CH), .WIDTH(W)) bus1 ();
  thermo_decoder_pipe_if #(.CHANNELS(CH), .WIDTH(W)) bus0 ();

  thermo_decoder_pipe #(.CHANNELS(CH), .WIDTH(W), .BUBBLE_FIX(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  thermo_decoder_pipe #(.CHANNELS(CH), .WIDTH(W), .BUBBLE_FIX(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));

  int n_chk = 0;
  int n_err = 0;

  int lat1, lat0, hi1, hi0;
  logic [CH*OW-1:0] code1, code0;
  logic [CH-1:0]    sat1, err1, sat0, err0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] c0, input logic [W-1:0] c1);
    bus1.in_valid = v;
    bus1.data_in  = {c1, c0};
    bus0.in_valid = v;
    bus0.data_in  = {c1, c0};
  endtask

  function automatic logic [W-1:0] therm(input int n);
    logic [W-1:0] ones;
    ones = '1;
    return (n <= 0) ? '0 : (ones >> (W - n));
  endfunction

  function automatic logic [CH*OW-1:0] codes(input int c0, input int c1);
    logic [OW-1:0] a, b;
    a = OW'(c0);
    b = OW'(c1);
    return {b, a};
  endfunction

  // One-cycle pulse, then watch both instances for up to 20 cycles.
  task automatic pulse(input logic [W-1:0] c0, input logic [W-1:0] c1);
    lat1 = 0; lat0 = 0; hi1 = 0; hi0 = 0;
    @(negedge clk);
    drive(1'b1, c0, c1);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      drive(1'b0, c0, c1);
      if (bus1.out_valid) begin
        hi1++;
        if (lat1 == 0) begin
          lat1 = n; code1 = bus1.code_out; sat1 = bus1.sat_out; err1 = bus1.err_out;
        end
      end
      if (bus0.out_valid) begin
        hi0++;
        if (lat0 == 0) begin
          lat0 = n; code0 = bus0.code_out; sat0 = bus0.sat_out; err0 = bus0.err_out;
        end
      end
    end
  endtask

  initial begin
    int highs, first, last, j;
    logic [W-1:0] r0, r1;

    // Reset with garbage on the inputs
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      r0 = W'({$urandom(), $urandom()});
      r1 = W'({$urandom(), $urandom()});
      drive(1'b1, r0, r1);
    end
    @(negedge clk);
    chk_eq("rst_valid", {62'd0, bus1.out_valid, bus0.out_valid}, 64'd0);
    chk_eq("rst_code", {40'd0, bus1.code_out, bus0.code_out}, 64'd0);
    chk_eq("rst_sat", {60'd0, bus1.sat_out, bus0.sat_out}, 64'd0);
    chk_eq("rst_err", {60'd0, bus1.err_out, bus0.err_out}, 64'd0);
    drive(1'b0, r0, r1);
    rst = 1'b0;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.out_valid || bus0.out_valid) highs++;
    end
    chk_eq("idle_valid", highs, 0);

    // Basic decode
    pulse(therm(16), '0);
    chk_eq("basic_lat", lat1, 8);
    chk_eq("basic_once", hi1, 1);
    chk_eq("basic_code", code1, codes(16, 0));
    chk_eq("basic_sat", sat1, 2'b00);
    chk_eq("basic_err", err1, 2'b00);
    chk_eq("basic_lat_nf", lat0, 7);
    chk_eq("basic_code_nf", code0, codes(16, 0));

    // Saturation
    pulse(40'hFF_FFFF_FFFF, 40'h00_0000_0001);
    chk_eq("sat_code", code1, codes(40, 1));
    chk_eq("sat_sat", sat1, 2'b01);
    chk_eq("sat_err", err1, 2'b00);
    chk_eq("sat_sat_nf", sat0, 2'b01);

    // Single-bit bubbles: filtered vs raw
    pulse(40'h00_0000_00BF, 40'h00_0000_0FFD);
    chk_eq("bub_code", code1, codes(7, 12));
    chk_eq("bub_err", err1, 2'b00);
    chk_eq("bub_lat_nf", lat0, 7);
    chk_eq("bub_code_nf", code0, codes(8, 12));
    chk_eq("bub_err_nf", err0, 2'b11);

    // Streaming sweep, both directions
    j = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (bus1.out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        chk_eq($sformatf("strm_code%0d", j), bus1.code_out, codes(j, W - j));
        chk_eq($sformatf("strm_sat%0d", j), bus1.sat_out,
               {(j == 0) ? 1'b1 : 1'b0, (j == W) ? 1'b1 : 1'b0});
        j++;
      end
      if (cyc <= W) drive(1'b1, therm(cyc), therm(W - cyc));
      else          drive(1'b0, '0, '0);
    end
    chk_eq("strm_count", j, W + 1);
    chk_eq("strm_contig", last - first + 1, W + 1);
    chk_eq("strm_hold_valid", bus1.out_valid, 1'b0);
    chk_eq("strm_hold_code", bus1.code_out, codes(W, 0));

    // Reset while three words are still in flight
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, therm(5 + 2 * i), therm(1 + i));
    end
    highs = 0;
    for (int n = 0; n < 20 && highs == 0; n++) begin
      @(negedge clk);
      drive(1'b0, '0, '0);
      if (bus1.out_valid) highs = 1;
    end
    chk_eq("ro_first_seen", highs, 1);
    chk_eq("ro_first_code", bus1.code_out, codes(5, 1));
    #1 rst = 1'b1;
    #1;
    chk_eq("ro_valid_async", bus1.out_valid, 1'b0);
    chk_eq("ro_code_async", bus1.code_out, '0);
    @(negedge clk);
    rst = 1'b0;
    highs = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus1.out_valid || bus0.out_valid) highs++;
    end
    chk_eq("ro_no_ghosts", highs, 0);
    pulse(therm(23), therm(2));
    chk_eq("ro_after_lat", lat1, 8);
    chk_eq("ro_after_code", code1, codes(23, 2));
    chk_eq("ro_after_once", hi1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/thermo_decoder_pipe.md
# thermo_decoder_pipe

Parametrised, fully pipelined thermometer-to-binary decoder for the TDC tapped-delay-line capture path. Each of CHANNELS channels receives a WIDTH-bit thermometer word (ones filled from bit 0 upward) and produces the count of ones as a binary fine-time code. The search is a pipelined binary (halving) search, one bit per stage. This generation adds:
- a selectable bubble-error filter,
- saturation and code-error flags,
- a valid pipeline with asynchronous reset.

It sits between the delay-line capture registers and the coarse/fine timestamp merger.

## Interface
- CHANNELS, 2, number of independent delay-line channels sharing one valid strobe
- WIDTH, 40, thermometer bits per channel (≥2)
- BUBBLE_FIX, 1, 1 = insert a majority-of-3 bubble filter stage; 0 = bypass (no stage)
- clk  in  1  capture clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  data_in holds a capture this cycle
- data_in  in  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- out_valid  out  1  code_out/sat_out/err_out carry a new result this cycle
- code_out  out  CHANNELS*OUT_W  channel c at [c*OUT_W +: OUT_W], OUT_W = clog2(WIDTH+1)
- sat_out  out  CHANNELS  channel word was all ones (edge not captured)
- err_out  out  CHANNELS  filtered word was not a legal thermometer code

## Operation
- **Padding:** P = 2^OUT_W − 1. Each word is zero-extended to P bits at the input register.
- **Bubble filter** (BUBBLE_FIX=1):
  - f[i] = maj(t[i−1], t[i], t[i+1]), with t[−1]=1 and t[WIDTH]=0.
  - With BUBBLE_FIX=0, f = t.
- **Search:** OUT_W stages. Stage k (k = OUT_W−1 … 1) inspects the middle bit (index 2^k − 1) of the current 2^(k+1) − 1 bit slice.
  - If the bit is 1: the code bit is 1 and the upper half is kept.
  - If the bit is 0: the code bit is 0 and the lower half is kept.
  - The final stage takes the surviving single bit as code LSB.
  - Result equals the popcount for legal thermometer words. Illegal words give the deterministic search result, not the popcount.
- **sat:** AND of all WIDTH filtered bits; code is then WIDTH.
- **err:** OR over i of (f[i+1] & ~f[i]).
- **Flag alignment:** sat and err are computed in the filter stage (input stage when BUBBLE_FIX=0) and delay-matched to the code.
- **Valid path:** a shift register of length L carries in_valid. All data stages advance every cycle regardless of valid.
- **Output hold:** output registers load only when the delayed valid is 1, and hold their last value otherwise.
- **No backpressure:** throughput is one word per cycle per channel; channels run in lock-step.

## Timing
- Latency L = OUT_W + 1 + BUBBLE_FIX cycles, from the in_valid sampling edge to out_valid high. Default L = 8 (7 with BUBBLE_FIX=0).
- out_valid is high for exactly one cycle per accepted input. Back-to-back inputs produce back-to-back outputs in order.
- **Reset values:** all outputs 0; valid shift register 0; data stage registers 0.
- **Reset during operation:** asserting rst clears out_valid asynchronously. In-flight words are discarded, and none emerge after release.
- The first in_valid accepted after rst deasserts yields out_valid L cycles later.
- in_valid held low: out_valid stays 0 and outputs keep their last result.

## Structure
- Package tdc_pkg holds:
  - the constant functions clog2 and pad_width(W) = 2^clog2(W+1) − 1;
  - the OUT_W derivation;
  - shared by the future timestamp merger.
- Sub-module thermo_search_ch:
  - one channel's filter, search stages and flag delay;
  - generate-instantiated CHANNELS times;
  - parameters WIDTH and BUBBLE_FIX.
- The top level owns the single valid shift register and the output-enable registers.

## Test plan
Defaults unless stated: CHANNELS=2, WIDTH=40, BUBBLE_FIX=1.
- **Reset:** rst=1 with random data_in and in_valid=1 → all outputs 0. Release rst with in_valid=0 for 20 cycles → out_valid stays 0.
- **Basic decode:** one pulse, ch0=40'h000000FFFF, ch1=0 → 8 cycles later out_valid=1, code ch0=16, ch1=0, sat=00, err=00.
- **Saturation:** ch0=40'hFFFFFFFFFF, ch1=40'h0000000001 → code ch0=40, ch1=1, sat=01, err=00.
- **Bubble handling:**
  - ch0=40'h00000000BF (bit 6 missing) → code 7, err=0.
  - Same stimulus with BUBBLE_FIX=0 → code 8, err=1, latency 7.
- **Streaming:** in_valid continuous, ch0 sweeping codes 0…40 and ch1 sweeping 40…0 → identical sequence out, out_valid contiguous for 41 cycles, then outputs held.
- **Reset during operation:** 3 words in flight, pulse rst for one cycle mid-cycle → out_valid falls immediately. No output appears for those words. The next input after release decodes correctly after 8 cycles.
